// File: rtl/select_decode_if.sv
// Bus between the control unit and the select/decode block: IR load, G-select strobes,
// register enable outputs and the decoded instruction fields.
interface select_decode_if #(
  parameter int unsigned REG_COUNT = 16
);
  logic [31:0]          BusMuxOut;
  logic                 IRin;
  logic                 Gra;
  logic                 Grb;
  logic                 Grc;
  logic                 Rin;
  logic                 Rout;
  logic                 BAout;
  logic [31:0]          IR;
  logic [4:0]           opcode;
  logic [REG_COUNT-1:0] R_in;
  logic [REG_COUNT-1:0] R_out;
  logic                 R0_zero;
  logic [31:0]          C_sign_extended;
  logic                 ir_valid;
  logic                 sel_err;

  modport master (
    output BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
    input  IR, opcode, R_in, R_out, R0_zero, C_sign_extended, ir_valid, sel_err
  );

  modport slave (
    input  BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
    output IR, opcode, R_in, R_out, R0_zero, C_sign_extended, ir_valid, sel_err
  );
endinterface

// File: rtl/select_decode.sv
// Instruction register capture plus Ra/Rb/Rc select decode into one-hot R_in/R_out enables.
// Optional SELECT_DECODE_BA_R0_ZERO_EN: BAout on R0 drives zero onto the bus instead of R0.
module select_decode #(
  parameter int unsigned C_WIDTH   = 19,
  parameter int unsigned REG_COUNT = 16
) (
  input  logic          clock,
  input  logic          clear_n,
  select_decode_if.slave bus
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned EXT_W   = DATA_W - C_WIDTH;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_LSB  = 15;

  typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

  state_t              state;
  logic [DATA_W-1:0]   ir_q;
  logic                rin_d;
  logic                sel_err_q;

  logic                valid;
  logic                any_g;
  logic                multi_g;
  logic                conflict;
  logic [FIELD_W-1:0]  sel_field;
  logic [REG_COUNT-1:0] onehot;
  logic                ba_r0;

  // IR capture, EMPTY/VALID tracking, Rin edge history and sticky conflict flag
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= EMPTY;
      ir_q      <= '0;
      rin_d     <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      rin_d <= bus.Rin;
      if (bus.IRin) begin
        ir_q  <= bus.BusMuxOut;
        state <= VALID;
      end
      if (conflict)
        sel_err_q <= 1'b1;
      else if (bus.IRin)
        sel_err_q <= 1'b0;
    end
  end

  // Priority select Gra > Grb > Grc, decoded from the IR currently held
  always_comb begin
    sel_field = '0;
    onehot    = '0;
    if (bus.Gra)
      sel_field = ir_q[RA_LSB +: FIELD_W];
    else if (bus.Grb)
      sel_field = ir_q[RB_LSB +: FIELD_W];
    else if (bus.Grc)
      sel_field = ir_q[RC_LSB +: FIELD_W];
    if (any_g)
      onehot = REG_COUNT'(1) << sel_field;
  end

  assign valid    = (state == VALID);
  assign any_g    = bus.Gra | bus.Grb | bus.Grc;
  assign multi_g  = (bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc);
  assign conflict = multi_g & (bus.Rin | bus.Rout | bus.BAout);

`ifdef SELECT_DECODE_BA_R0_ZERO_EN
  // Base-address reads of R0 put zero on the bus; BAout dominates a concurrent Rout
  assign ba_r0 = valid & bus.BAout & any_g & (sel_field == FIELD_W'(0));
`else
  assign ba_r0 = 1'b0;
`endif

  assign bus.IR              = ir_q;
  assign bus.opcode          = ir_q[DATA_W-1 -: 5];
  assign bus.ir_valid        = valid;
  assign bus.sel_err         = sel_err_q;
  assign bus.R0_zero         = ba_r0;
  assign bus.R_out           = (valid & (bus.Rout | bus.BAout) & ~ba_r0) ? onehot : '0;
  assign bus.R_in            = (valid & bus.Rin & ~rin_d) ? onehot : '0;
  assign bus.C_sign_extended = valid ? {{EXT_W{ir_q[C_WIDTH-1]}}, ir_q[C_WIDTH-1:0]}
                                     : '0;
endmodule

// File: tb/tb_select_decode.sv
// Directed bench for select_decode: reset, IR decode, Rin one-shot, priority/conflict,
// BAout on R0 and same-cycle IRin/Rout ordering.
module tb_select_decode;
  logic clock;
  logic clear_n;
  int   errors;
  int   checks;

  select_decode_if #(.REG_COUNT(16)) bus ();

  select_decode #(.C_WIDTH(19), .REG_COUNT(16)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.BusMuxOut = 32'h0;
    bus.IRin  = 1'b0;
    bus.Gra   = 1'b0;
    bus.Grb   = 1'b0;
    bus.Grc   = 1'b0;
    bus.Rin   = 1'b0;
    bus.Rout  = 1'b0;
    bus.BAout = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    bus.BusMuxOut = v;
    bus.IRin      = 1'b1;
    next_cycle();
    bus.IRin      = 1'b0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    idle_inputs();
    #2;
    checks++; if (bus.IR !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h exp %h", bus.IR, 32'h0); end
    checks++; if (bus.R_out !== 16'h0) begin errors++; $display("FAIL reset_rout: got %h exp %h", bus.R_out, 16'h0); end
    checks++; if (bus.R_in !== 16'h0) begin errors++; $display("FAIL reset_rin: got %h exp %h", bus.R_in, 16'h0); end
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.ir_valid); end
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL reset_selerr: got %b exp 0", bus.sel_err); end
    checks++; if (bus.C_sign_extended !== 32'h0) begin errors++; $display("FAIL reset_c: got %h exp 0", bus.C_sign_extended); end
    repeat (2) @(posedge clock);
    #1;
    clear_n  = 1'b1;
    bus.Gra  = 1'b1;
    bus.Rout = 1'b1;
    bus.Rin  = 1'b1;
    @(negedge clock);
    checks++; if (bus.R_out !== 16'h0) begin errors++; $display("FAIL empty_rout: got %h exp %h", bus.R_out, 16'h0); end
    checks++; if (bus.R_in !== 16'h0) begin errors++; $display("FAIL empty_rin: got %h exp %h", bus.R_in, 16'h0); end
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b exp 0", bus.ir_valid); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_ir_decode();
    load_ir(32'h1A2C_0005);
    checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL decode_valid: got %b exp 1", bus.ir_valid); end
    checks++; if (bus.opcode !== 5'd3) begin errors++; $display("FAIL decode_opcode: got %0d exp 3", bus.opcode); end
    checks++; if (bus.C_sign_extended !== 32'hFFFC_0005) begin errors++; $display("FAIL decode_c1: got %h exp %h", bus.C_sign_extended, 32'hFFFC_0005); end
    bus.Rout = 1'b1;
    bus.Gra  = 1'b1;
    @(negedge clock);
    checks++; if (bus.R_out !== 16'h0010) begin errors++; $display("FAIL decode_ra: got %h exp %h", bus.R_out, 16'h0010); end
    bus.Gra = 1'b0; bus.Grb = 1'b1;
    #1;
    checks++; if (bus.R_out !== 16'h0020) begin errors++; $display("FAIL decode_rb: got %h exp %h", bus.R_out, 16'h0020); end
    bus.Grb = 1'b0; bus.Grc = 1'b1;
    #1;
    checks++; if (bus.R_out !== 16'h0100) begin errors++; $display("FAIL decode_rc: got %h exp %h", bus.R_out, 16'h0100); end
    bus.Grc = 1'b0;
    #1;
    checks++; if (bus.R_out !== 16'h0000) begin errors++; $display("FAIL decode_nosel: got %h exp %h", bus.R_out, 16'h0000); end
    next_cycle();
    idle_inputs();
    load_ir(32'h0004_0000);
    checks++; if (bus.C_sign_extended !== 32'hFFFC_0000) begin errors++; $display("FAIL decode_c2: got %h exp %h", bus.C_sign_extended, 32'hFFFC_0000); end
    load_ir(32'h0003_FFFF);
    checks++; if (bus.C_sign_extended !== 32'h0003_FFFF) begin errors++; $display("FAIL decode_c3: got %h exp %h", bus.C_sign_extended, 32'h0003_FFFF); end
  endtask

  task automatic test_rin_oneshot();
    logic [15:0] exp_rin [0:4];
    exp_rin[0] = 16'h0080; exp_rin[1] = 16'h0000; exp_rin[2] = 16'h0000;
    exp_rin[3] = 16'h0000; exp_rin[4] = 16'h0080;
    load_ir(32'h0380_0000);
    bus.Gra = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.Rin = (i != 3);
      @(negedge clock);
      checks++;
      if (bus.R_in !== exp_rin[i]) begin
        errors++; $display("FAIL rin_oneshot[%0d]: got %h exp %h", i, bus.R_in, exp_rin[i]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_conflict();
    load_ir(32'h0148_0000);
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL conflict_pre: got %b exp 0", bus.sel_err); end
    bus.Gra = 1'b1; bus.Grb = 1'b1; bus.Rout = 1'b1;
    @(negedge clock);
    checks++; if (bus.R_out !== 16'h0004) begin errors++; $display("FAIL conflict_prio: got %h exp %h", bus.R_out, 16'h0004); end
    next_cycle();
    idle_inputs();
    checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b exp 1", bus.sel_err); end
    next_cycle();
    checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b exp 1", bus.sel_err); end
    load_ir(32'h0148_0000);
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL conflict_clear: got %b exp 0", bus.sel_err); end
    bus.Grb = 1'b1; bus.Grc = 1'b1; bus.Rin = 1'b1;
    load_ir(32'h0148_0000);
    idle_inputs();
    checks++; if (bus.sel_err !== 1'b1) begin errors++; $display("FAIL conflict_setwins: got %b exp 1", bus.sel_err); end
    load_ir(32'h0000_0000);
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL conflict_clear2: got %b exp 0", bus.sel_err); end
  endtask

  task automatic test_ba_r0();
    load_ir(32'h0100_0000);
    bus.Grb = 1'b1; bus.BAout = 1'b1;
    @(negedge clock);
`ifdef SELECT_DECODE_BA_R0_ZERO_EN
    checks++; if (bus.R_out !== 16'h0000) begin errors++; $display("FAIL ba_r0_rout: got %h exp %h", bus.R_out, 16'h0000); end
    checks++; if (bus.R0_zero !== 1'b1) begin errors++; $display("FAIL ba_r0_zero: got %b exp 1", bus.R0_zero); end
`else
    checks++; if (bus.R_out !== 16'h0001) begin errors++; $display("FAIL ba_r0_rout: got %h exp %h", bus.R_out, 16'h0001); end
    checks++; if (bus.R0_zero !== 1'b0) begin errors++; $display("FAIL ba_r0_zero: got %b exp 0", bus.R0_zero); end
`endif
    bus.BAout = 1'b0; bus.Rout = 1'b1;
    #1;
    checks++; if (bus.R_out !== 16'h0001) begin errors++; $display("FAIL rout_r0: got %h exp %h", bus.R_out, 16'h0001); end
    checks++; if (bus.R0_zero !== 1'b0) begin errors++; $display("FAIL rout_r0_zero: got %b exp 0", bus.R0_zero); end
    bus.Rout = 1'b0; bus.Grb = 1'b0; bus.Gra = 1'b1; bus.BAout = 1'b1;
    #1;
    checks++; if (bus.R_out !== 16'h0004) begin errors++; $display("FAIL ba_r2: got %h exp %h", bus.R_out, 16'h0004); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_irin_rout_same_cycle();
    load_ir(32'h0180_0000);
    bus.BusMuxOut = 32'h0300_0000;
    bus.IRin = 1'b1; bus.Gra = 1'b1; bus.Rout = 1'b1;
    @(negedge clock);
    checks++; if (bus.R_out !== 16'h0008) begin errors++; $display("FAIL same_cycle_old: got %h exp %h", bus.R_out, 16'h0008); end
    next_cycle();
    bus.IRin = 1'b0;
    @(negedge clock);
    checks++; if (bus.R_out !== 16'h0040) begin errors++; $display("FAIL same_cycle_new: got %h exp %h", bus.R_out, 16'h0040); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    load_ir(32'h0180_0000);
    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Rin = 1'b1;
    @(negedge clock);
    checks++; if (bus.R_in !== 16'h0008) begin errors++; $display("FAIL mid_rin_pre: got %h exp %h", bus.R_in, 16'h0008); end
    #2;
    clear_n = 1'b0;
    #1;
    checks++; if (bus.R_out !== 16'h0000) begin errors++; $display("FAIL mid_rout: got %h exp %h", bus.R_out, 16'h0000); end
    checks++; if (bus.IR !== 32'h0) begin errors++; $display("FAIL mid_ir: got %h exp %h", bus.IR, 32'h0); end
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b exp 0", bus.ir_valid); end
    next_cycle();
    clear_n = 1'b1;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ir_decode();
    test_rin_oneshot();
    test_conflict();
    test_ba_r0();
    test_irin_rout_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
